debug_tx_arbiter: RTL and testbench

Packet-level scheduler that shares the debug core's single UART byte transmitter between several message sources (signal dump, ping OK, breakpoint-hit notify). It snapshots one requester's multi-byte payload and serialises it LSB-byte-first through the transmitter's start/busy/done handshake. Arbitration is round-robin and packets are atomic. The block sits between the debug command logic and the UART TX shifter.

---
 rtl/debug_tx_arbiter_pkg.sv | 36 +++
 rtl/debug_rr_arbiter.sv | 36 +++
 rtl/debug_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_debug_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_tx_arbiter_pkg.sv
// Shared definitions for the debug UART packet scheduler.
// Contents: FSM state encodings, default payload width and the client opcodes
// that requesters place in payload byte 0.
// Build option: DEBUG_TX_CHECKSUM_EN adds the DTX_CSUM trailer state.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

package debug_tx_arbiter_pkg;

    // Default payload holds two ISA words (e.g. a PC plus an instruction).
    localparam int unsigned DTX_PAYLOAD_WIDTH = `ISA_WIDTH * 2;

`ifdef DEBUG_TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        DTX_IDLE = 3'd0,
        DTX_SEND = 3'd1,
        DTX_WAIT = 3'd2,
        DTX_DONE = 3'd3,
        DTX_CSUM = 3'd4
    } dtx_state_e;
`else
    typedef enum logic [1:0] {
        DTX_IDLE = 2'd0,
        DTX_SEND = 2'd1,
        DTX_WAIT = 2'd2,
        DTX_DONE = 2'd3
    } dtx_state_e;
`endif

    // Client response opcodes, sent as the first byte of each packet.
    localparam logic [7:0] DTX_OP_SIGNAL_DUMP = 8'h01;
    localparam logic [7:0] DTX_OP_PING_OK     = 8'h02;
    localparam logic [7:0] DTX_OP_BP_HIT      = 8'h03;

endpackage

// File: rtl/debug_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from the
// pointer, wrapping modulo NUM_REQ. The pointer register lives in the parent.
// Ports: req_i (requests), rr_ptr_i (scan start), gnt_vld_c (any request),
//        gnt_c (one-hot grant), gnt_idx_c (grant index).
module debug_rr_arbiter
    import debug_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               gnt_vld_c,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    logic [IDX_W-1:0] cand;

    // Priority scan rotated by the pointer; first hit wins.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_c     = '0;
        gnt_idx_c = '0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(rr_ptr_i) + off) % NUM_REQ);
            if (!gnt_vld_c && req_i[cand]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand;
                gnt_c     = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/debug_tx_arbiter.sv
// Packet scheduler sharing one UART byte transmitter among debug requesters.
// Snapshots the winner's payload, then sends bytes LSB-first via start/busy/done.
// Ports: clk, rst_n (async, active low), hold (block new grants),
//        req/req_len/req_data (requester side), ack/done (one-hot pulses),
//        busy (packet in flight), tx_data/tx_start/tx_busy/tx_done (transmitter).
// Build option: DEBUG_TX_CHECKSUM_EN appends an XOR checksum byte per packet.
module debug_tx_arbiter
    import debug_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned PAYLOAD_WIDTH = DTX_PAYLOAD_WIDTH,
    parameter int unsigned LEN_WIDTH     = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             hold,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               ack,
    output logic [NUM_REQ-1:0]               done,
    output logic                             busy,
    output logic [7:0]                       tx_data,
    output logic                             tx_start,
    input  logic                             tx_busy,
    input  logic                             tx_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dtx_state_e               state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [LEN_WIDTH-1:0]     byte_idx_q, byte_idx_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [PAYLOAD_WIDTH-1:0] buf_q, buf_d;
    logic [NUM_REQ-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic [NUM_REQ-1:0]       done_q, done_d;
    logic                     busy_q, busy_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_start_q, tx_start_d;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
    logic                     csum_sent_q, csum_sent_d;
`endif

    logic                     gnt_vld_c;
    logic [NUM_REQ-1:0]       gnt_c;
    logic [IDX_W-1:0]         gnt_idx_c;
    logic [PAYLOAD_WIDTH-1:0] data_sel;
    logic [LEN_WIDTH-1:0]     len_sel;
    logic [7:0]               cur_byte;

    debug_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_vld_c (gnt_vld_c),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Select the winner's payload and length slices.
    always_comb begin
        data_sel = '0;
        len_sel  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_c == IDX_W'(i)) begin
                data_sel = req_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                len_sel  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        byte_idx_d = byte_idx_q;
        len_d      = len_q;
        buf_d      = buf_q;
        owner_d    = owner_q;
        ack_d      = '0;
        done_d     = '0;
        busy_d     = busy_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        cur_byte   = 8'(buf_q >> {byte_idx_q, 3'b000});

        case (state_q)
            DTX_IDLE: begin
                if (!hold && gnt_vld_c) begin
                    buf_d      = data_sel;
                    len_d      = len_sel;
                    owner_d    = gnt_c;
                    ack_d      = gnt_c;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    rr_ptr_d   = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : gnt_idx_c + IDX_W'(1);
`ifdef DEBUG_TX_CHECKSUM_EN
                    csum_d      = '0;
                    csum_sent_d = 1'b0;
`endif
                    state_d    = DTX_SEND;
                end
            end
            DTX_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    csum_d     = csum_q ^ cur_byte;
`endif
                    state_d    = DTX_WAIT;
                end
            end
            DTX_WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q == len_q) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                        state_d = DTX_CSUM;
`else
                        state_d = DTX_DONE;
`endif
                    end else begin
                        byte_idx_d = byte_idx_q + LEN_WIDTH'(1);
                        state_d    = DTX_SEND;
                    end
                end
            end
`ifdef DEBUG_TX_CHECKSUM_EN
            // Trailer: launch once the transmitter is free, then wait for its done.
            DTX_CSUM: begin
                if (!csum_sent_q) begin
                    if (!tx_busy) begin
                        tx_data_d   = csum_q;
                        tx_start_d  = 1'b1;
                        csum_sent_d = 1'b1;
                    end
                end else if (tx_done) begin
                    state_d = DTX_DONE;
                end
            end
`endif
            DTX_DONE: begin
                done_d  = owner_q;
                busy_d  = 1'b0;
                state_d = DTX_IDLE;
            end
            default: state_d = DTX_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DTX_IDLE;
            rr_ptr_q   <= '0;
            byte_idx_q <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            owner_q    <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_idx_q <= byte_idx_d;
            len_q      <= len_d;
            buf_q      <= buf_d;
            owner_q    <= owner_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

`ifndef SYNTHESIS
    // A granted length must address a byte inside the payload.
    len_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DTX_IDLE && !hold && gnt_vld_c) |-> (32'(len_sel) <= PAYLOAD_WIDTH / 8 - 1));
`endif

endmodule

// File: tb/tb_debug_tx_arbiter.sv
`timescale 1ns/1ps
module tb_debug_tx_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned PW = 64;
    localparam int unsigned LW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            hold;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*PW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    done;
    logic            busy;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            tx_done;

    debug_tx_arbiter #(.NUM_REQ(N), .PAYLOAD_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .req      (req),
        .req_len  (req_len),
        .req_data (req_data),
        .ack      (ack),
        .done     (done),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: packet-level view of the scheduler.
    bit           m_idle, m_active, m_pending, m_wait, m_done_due;
    int           m_ptr;
    logic [N-1:0] m_owner;
    logic [7:0]   m_q[$];
    int           grant_log[$];
    logic [7:0]   sent_log[$];
    int           start_cyc[$];
    int           ack_cyc, done_cnt, bytes_done;
    int           grants_per[N];

    // Transmitter model.
    bit tx_inflight, rnd_tx;
    int tx_cnt, stall_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_idle = 1; m_active = 0; m_pending = 0; m_wait = 0; m_done_due = 0;
        m_ptr = 0; m_owner = '0; m_q.delete();
        tx_inflight = 0; tx_cnt = 0; stall_cnt = 0; tx_busy = 0; tx_done = 0;
    endtask

    task automatic capture(input int w);
        logic [PW-1:0] d;
        int len;
        d   = req_data[w*PW +: PW];
        len = int'(req_len[w*LW +: LW]);
        m_q.delete();
        for (int b = 0; b <= len; b++) m_q.push_back(d[b*8 +: 8]);
`ifdef DEBUG_TX_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = '0;
            for (int b = 0; b <= len; b++) cs ^= d[b*8 +: 8];
            m_q.push_back(cs);
        end
`endif
        m_owner = N'(1) << w;
        m_ptr   = (w + 1) % N;
        m_idle  = 0; m_active = 1; m_pending = 1;
        grant_log.push_back(w);
        grants_per[w]++;
    endtask

    // Compare DUT outputs after an edge against the model, then advance the model.
    task automatic observe();
        logic [N-1:0] exp_ack, exp_done;
        bit gnt, consumed, exp_start, done_next;
        int w;
        logic [7:0] eb;
        exp_ack = '0; gnt = 0; w = 0; done_next = 0;
        if (m_idle && !hold && req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!gnt && req[(m_ptr + k) % N]) begin
                    gnt = 1; w = (m_ptr + k) % N;
                end
            end
            exp_ack = N'(1) << w;
        end
        check_eq("ack", ack, exp_ack);
        if (ack != '0) ack_cyc = cyc;

        consumed  = tx_done && m_wait;
        exp_start = m_pending && !tx_busy;
        check_eq("tx_start", tx_start, exp_start);
        if (tx_start) begin sent_log.push_back(tx_data); start_cyc.push_back(cyc); end
        if (exp_start) begin
            eb = (m_q.size() > 0) ? m_q.pop_front() : 8'hxx;
            check_eq("tx_data", tx_data, eb);
            m_pending = 0; m_wait = 1;
        end
        if (consumed) begin
            m_wait = 0; bytes_done++;
            if (m_q.size() > 0) m_pending = 1; else done_next = 1;
        end

        exp_done = m_done_due ? m_owner : '0;
        check_eq("done", done, exp_done);
        if (m_done_due) begin m_idle = 1; m_active = 0; done_cnt++; end
        m_done_due = done_next;

        if (gnt) capture(w);
        check_eq("busy", busy, m_active);
    endtask

    task automatic drive_tx();
        if (tx_start) begin tx_inflight = 1; tx_cnt = $urandom_range(1, 4); end
        tx_done = 0;
        if (tx_inflight) begin
            if (tx_cnt > 0) begin tx_busy = 1; tx_cnt--; end
            else begin tx_busy = 0; tx_done = 1; tx_inflight = 0; end
        end else if (stall_cnt > 0) begin
            tx_busy = 1; stall_cnt--;
        end else begin
            tx_busy = 0;
            if (rnd_tx) begin
                if ($urandom_range(0, 15) == 0) stall_cnt = $urandom_range(1, 6);
                else if (!m_wait && $urandom_range(0, 15) == 0) tx_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe();
        drive_tx();
    endtask

    task automatic set_req(input int i, input int len, input logic [PW-1:0] d);
        req_len[i*LW +: LW]  = LW'(len);
        req_data[i*PW +: PW] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int start, n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < bound) begin tick(); n++; end
        check_eq({tag, "_finished"}, 64'(done_cnt != start), 64'd1);
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (!m_idle && n < bound) begin tick(); n++; end
        check_eq({tag, "_idle"}, 64'(m_idle), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, ack, '0);
        check_eq({tag, "_done"}, done, '0);
        check_eq({tag, "_busy"}, busy, '0);
        check_eq({tag, "_tx_data"}, tx_data, '0);
        check_eq({tag, "_tx_start"}, tx_start, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int csum_extra;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_extra = 1;
`else
        csum_extra = 0;
`endif
        rst_n = 0; hold = 0; req = '0; req_len = '0; req_data = '0; rnd_tx = 0;
        done_cnt = 0; bytes_done = 0; ack_cyc = 0;
        for (int i = 0; i < N; i++) grants_per[i] = 0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1; rst_n = 1;

        // Contention: all three held from rr_ptr=0.
        for (int i = 0; i < N; i++) set_req(i, 0, 64'(8'hC0 + i));
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin tick(); n++; end
        req = '0;
        drain("contend", 200);
        check_eq("rr_grant0", grant_log[0], 0);
        check_eq("rr_grant1", grant_log[1], 1);
        check_eq("rr_grant2", grant_log[2], 2);
        check_eq("rr_grant3", grant_log[3], 0);

        // Single packet from requester 1.
        sent_log.delete(); start_cyc.delete();
        set_req(1, 2, 64'h0000_0000_0033_2211);
        tick();
        check_eq("single_ack", ack, 3'b010);
        req[1] = 0;
        wait_done("single", 200);
        check_eq("single_b0", sent_log[0], 8'h11);
        check_eq("single_b1", sent_log[1], 8'h22);
        check_eq("single_b2", sent_log[2], 8'h33);
        check_eq("single_latency", start_cyc[0] - ack_cyc, 1);

        // Snapshot: payload overwritten right after ack.
        sent_log.delete();
        set_req(0, 7, 64'h0807_0605_0403_0201);
        tick();
        check_eq("snap_ack", ack, 3'b001);
        req_data[0 +: PW] = '1;
        req[0] = 0;
        wait_done("snap", 300);
        for (int b = 0; b < 8; b++) check_eq("snap_byte", sent_log[b], 64'(b + 1));

        // Backpressure: transmitter busy for 50 cycles while in SEND.
        sent_log.delete(); start_cyc.delete();
        set_req(2, 0, 64'h5A);
        tx_busy = 1; stall_cnt = 50;
        tick();
        check_eq("bp_ack", ack, 3'b100);
        req[2] = 0;
        wait_done("bp", 300);
        check_eq("bp_start_gap", start_cyc[0] - ack_cyc, 51);
        check_eq("bp_start_count", start_cyc.size(), 1 + csum_extra);

        // Reset in the middle of a packet, then rr_ptr must be back at 0.
        set_req(1, 3, 64'h4433_2211);
        n = bytes_done;
        tick();
        req[1] = 0;
        while (bytes_done - n < 2 && cyc < 100000) tick();
        rst_n = 0;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        req = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        sent_log.delete();
        set_req(0, 0, 64'h77);
        set_req(2, 0, 64'h99);
        tick();
        check_eq("midrst_ack", ack, 3'b001);
        req = '0;
        wait_done("midrst", 200);
        check_eq("midrst_b0", sent_log[0], 8'h77);

        // Hold blocks new grants.
        hold = 1;
        set_req(1, 0, 64'h3C);
        for (int i = 0; i < 5; i++) tick();
        check_eq("hold_busy", busy, 1'b0);
        hold = 0;
        tick();
        check_eq("hold_release_ack", ack, 3'b010);
        req = '0;
        wait_done("hold", 200);

`ifdef DEBUG_TX_CHECKSUM_EN
        sent_log.delete();
        set_req(0, 1, 64'hF00F);
        tick();
        req = '0;
        wait_done("csum1", 200);
        check_eq("csum1_b0", sent_log[0], 8'h0F);
        check_eq("csum1_b1", sent_log[1], 8'hF0);
        check_eq("csum1_trl", sent_log[2], 8'hFF);
        sent_log.delete();
        set_req(0, 0, 64'hA5);
        tick();
        req = '0;
        wait_done("csum2", 200);
        check_eq("csum2_b0", sent_log[0], 8'hA5);
        check_eq("csum2_trl", sent_log[1], 8'hA5);
`endif

        // Randomized traffic with stalls, spurious tx_done and hold toggles.
        rnd_tx = 1;
        for (int i = 0; i < N; i++) grants_per[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if ($urandom_range(0, 31) == 0) hold = ~hold;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 0;
                    req_data[i*PW +: PW] = {$urandom(), $urandom()};
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    set_req(i, $urandom_range(0, 7), {$urandom(), $urandom()});
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req_data[i*PW +: PW] = {$urandom(), $urandom()};
                end
            end
        end
        req = '0; hold = 0; rnd_tx = 0;
        drain("random", 1000);
        for (int i = 0; i < N; i++) check_eq("random_served", 64'(grants_per[i] > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
